// File: rtl/amba_pkg.sv
// amba_pkg: shared AMBA codes and the AHB-to-APB bridge state encoding.
package amba_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } bridgeState_e;
endpackage

// File: rtl/ahb2apb_bridge_if.sv
// ahb2apb_bridge_if: AHB-Lite slave side and APB master side of the bridge.
interface ahb2apb_bridge_if #(parameter int ADDR_WIDTH = 32);
  logic iHSEL;
  logic [ADDR_WIDTH-1:0] iHADDR;
  logic iHWRITE;
  logic [1:0] iHTRANS;
  logic [2:0] iHSIZE;
  logic [31:0] iHWDATA;
  logic iHREADY;
  logic oHREADYOUT;
  logic oHRESP;
  logic [31:0] oHRDATA;
  logic oPSEL;
  logic oPENABLE;
  logic oPWRITE;
  logic [ADDR_WIDTH-1:0] oPADDR;
  logic [31:0] oPWDATA;
  logic [31:0] iPRDATA;
  logic iPREADY;
  logic iPSLVERR;
  modport slave (
    input iHSEL, iHADDR, iHWRITE, iHTRANS, iHSIZE, iHWDATA, iHREADY, iPRDATA, iPREADY, iPSLVERR,
    output oHREADYOUT, oHRESP, oHRDATA, oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA
  );
  modport master (
    output iHSEL, iHADDR, iHWRITE, iHTRANS, iHSIZE, iHWDATA, iHREADY, iPRDATA, iPREADY, iPSLVERR,
    input oHREADYOUT, oHRESP, oHRDATA, oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA
  );
endinterface

// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: converts AHB-Lite word transfers into APB SETUP/ACCESS sequences.
module ahb2apb_bridge
  import amba_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input logic iHCLK,
  input logic iHRESETn,
  ahb2apb_bridge_if.slave bus
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  bridgeState_e state, nextState;
  logic [CW-1:0] waitCnt;
  logic [ADDR_WIDTH-1:0] pAddr;
  logic pWrite;
  logic [31:0] pWdata, hRdata;
  logic canAccept, accept, timedOut;
  assign canAccept = state == ST_IDLE || state == ST_DONE || state == ST_ERR2;
  assign accept = canAccept && bus.iHSEL && bus.iHREADY && bus.iHTRANS[1];
  assign timedOut = TIMEOUT != 0 && waitCnt == CW'(TIMEOUT - 1);
  always_ff @(posedge iHCLK or negedge iHRESETn)
    if (!iHRESETn) state <= ST_IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR2:
        nextState = !accept ? ST_IDLE : bus.iHSIZE != HSIZE_WORD ? ST_ERR1 :
                    bus.iHWRITE ? ST_WDATA : ST_SETUP;
      ST_WDATA: nextState = ST_SETUP;
      ST_SETUP: nextState = ST_ACCESS;
      ST_ACCESS:
        nextState = bus.iPREADY ? (bus.iPSLVERR ? ST_ERR1 : ST_DONE) :
                    timedOut ? ST_ERR1 : ST_ACCESS;
      ST_ERR1: nextState = ST_ERR2;
      default: nextState = ST_IDLE;
    endcase
  end
  always_comb begin
    bus.oHREADYOUT = canAccept;
    bus.oHRESP = state == ST_ERR1 || state == ST_ERR2 ? HRESP_ERROR : HRESP_OKAY;
    bus.oPSEL = state == ST_SETUP || state == ST_ACCESS;
    bus.oPENABLE = state == ST_ACCESS;
  end
  // APB address/control only move on a legal accept, so they hold through ACCESS
  always_ff @(posedge iHCLK or negedge iHRESETn)
    if (!iHRESETn) begin
      pAddr <= '0;
      pWrite <= 1'b0;
      pWdata <= '0;
      hRdata <= '0;
      waitCnt <= '0;
    end else begin
      if (accept && bus.iHSIZE == HSIZE_WORD) begin
        pAddr <= {bus.iHADDR[ADDR_WIDTH-1:2], 2'b00};
        pWrite <= bus.iHWRITE;
      end
      if (state == ST_WDATA) pWdata <= bus.iHWDATA;
      if (state == ST_ACCESS && bus.iPREADY && !pWrite) hRdata <= bus.iPRDATA;
      waitCnt <= state == ST_ACCESS && !bus.iPREADY ? waitCnt + 1'b1 : '0;
    end
  assign bus.oPADDR = pAddr;
  assign bus.oPWRITE = pWrite;
  assign bus.oPWDATA = pWdata;
  assign bus.oHRDATA = hRdata;
endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb_ahb2apb_bridge: directed and random AHB transfers checked against a transaction-level model.
module tb_ahb2apb_bridge;
  import amba_pkg::*;
  localparam int TO = 16;
  logic iHCLK = 1'b0;
  logic iHRESETn = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [31:0] lastRd = '0;
  always #5 iHCLK = ~iHCLK;
  ahb2apb_bridge_if #(.ADDR_WIDTH(32)) bus ();
  assign bus.iHREADY = bus.oHREADYOUT;
  ahb2apb_bridge #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .iHCLK(iHCLK),
    .iHRESETn(iHRESETn),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    bus.iHSEL = 1'b0;
    bus.iHTRANS = HTRANS_IDLE;
    repeat (n) @(negedge iHCLK);
  endtask
  // Issues one address phase at the current negedge and follows its data phase to completion
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] size, input int waits, input bit slverr,
                      input logic [31:0] prdata);
    bit sizeOk = size == HSIZE_WORD;
    bit err, done;
    int access, expWs;
    int obsWs = 0;
    int pselN = 0;
    int penN = 0;
    int respN = 0;
    done = 1'b0;
    if (!sizeOk) begin
      access = 0;
      expWs = 1;
      err = 1'b1;
    end else if (waits >= TO) begin
      access = TO;
      expWs = (wr ? 2 : 1) + TO + 1;
      err = 1'b1;
    end else begin
      access = waits + 1;
      expWs = (wr ? 2 : 1) + access + int'(slverr);
      err = slverr;
      if (!wr) lastRd = prdata;
    end
    bus.iHSEL = 1'b1;
    bus.iHTRANS = $urandom_range(1) ? HTRANS_SEQ : HTRANS_NONSEQ;
    bus.iHADDR = addr;
    bus.iHWRITE = wr;
    bus.iHSIZE = size;
    for (int c = 0; c < 64; c++) begin
      @(negedge iHCLK);
      if (c == 0) begin
        bus.iHTRANS = HTRANS_IDLE;
        bus.iHWDATA = wdata;
        check("first_cycle_psel", 64'(bus.oPSEL), 64'(sizeOk && !wr));
      end
      if (bus.oHRESP) respN++;
      if (bus.oPSEL) begin
        pselN++;
        check("paddr", 64'(bus.oPADDR), 64'(addr & 32'hFFFF_FFFC));
        check("pwrite", 64'(bus.oPWRITE), 64'(wr));
        if (wr) check("pwdata", 64'(bus.oPWDATA), 64'(wdata));
      end
      if (bus.oPENABLE) penN++;
      bus.iPREADY = bus.oPENABLE && penN > waits;
      bus.iPSLVERR = bus.iPREADY && slverr;
      bus.iPRDATA = prdata;
      if (bus.oHREADYOUT) begin
        done = 1'b1;
        break;
      end
      obsWs++;
    end
    check("completed", 64'(done), 64'd1);
    check("wait_states", 64'(obsWs), 64'(expWs));
    check("hresp_cycles", 64'(respN), err ? 64'd2 : 64'd0);
    check("final_hresp", 64'(bus.oHRESP), 64'(err));
    check("psel_cycles", 64'(pselN), sizeOk ? 64'(access + 1) : 64'd0);
    check("penable_cycles", 64'(penN), 64'(access));
    check("hrdata", 64'(bus.oHRDATA), 64'(lastRd));
  endtask
  initial begin
    bus.iHSEL = 1'b0;
    bus.iHTRANS = HTRANS_IDLE;
    bus.iHADDR = '0;
    bus.iHWRITE = 1'b0;
    bus.iHSIZE = HSIZE_WORD;
    bus.iHWDATA = '0;
    bus.iPRDATA = '0;
    bus.iPREADY = 1'b0;
    bus.iPSLVERR = 1'b0;
    repeat (2) @(negedge iHCLK);
    check("rst_hreadyout", 64'(bus.oHREADYOUT), 64'd1);
    check("rst_hresp", 64'(bus.oHRESP), 64'd0);
    check("rst_psel", 64'(bus.oPSEL), 64'd0);
    check("rst_penable", 64'(bus.oPENABLE), 64'd0);
    check("rst_pwrite", 64'(bus.oPWRITE), 64'd0);
    check("rst_paddr", 64'(bus.oPADDR), 64'd0);
    check("rst_pwdata", 64'(bus.oPWDATA), 64'd0);
    check("rst_hrdata", 64'(bus.oHRDATA), 64'd0);
    iHRESETn = 1'b1;
    @(negedge iHCLK);
    xfer(1, 32'h4, 32'hF0, HSIZE_WORD, 0, 0, 32'h0);
    idle(1);
    xfer(0, 32'h0, 32'h0, HSIZE_WORD, 0, 0, 32'hA5A5_0003);
    idle(1);
    xfer(0, 32'h0, 32'h0, HSIZE_WORD, 3, 0, 32'h1234_5678);
    idle(1);
    xfer(0, 32'h20, 32'h0, HSIZE_WORD, TO - 1, 0, 32'hCAFE_0001);
    idle(1);
    xfer(0, 32'h24, 32'h0, HSIZE_WORD, TO, 0, 32'hBAD0_0000);
    idle(1);
    xfer(1, 32'h8, 32'hDEAD_BEEF, HSIZE_WORD, 0, 1, 32'h0);
    idle(1);
    xfer(0, 32'hC, 32'h0, 3'b000, 0, 0, 32'h0);
    idle(1);
    xfer(1, 32'h8, 32'h0000_0055, HSIZE_WORD, 0, 0, 32'h0);
    xfer(0, 32'hC, 32'h0, HSIZE_WORD, 0, 0, 32'h7777_1111);
    bus.iHSEL = 1'b1;
    bus.iHTRANS = HTRANS_BUSY;
    repeat (3) begin
      @(negedge iHCLK);
      check("busy_psel", 64'(bus.oPSEL), 64'd0);
      check("busy_hreadyout", 64'(bus.oHREADYOUT), 64'd1);
      check("busy_hresp", 64'(bus.oHRESP), 64'd0);
    end
    bus.iHSEL = 1'b0;
    bus.iHTRANS = HTRANS_NONSEQ;
    repeat (2) begin
      @(negedge iHCLK);
      check("unsel_psel", 64'(bus.oPSEL), 64'd0);
      check("unsel_hreadyout", 64'(bus.oHREADYOUT), 64'd1);
    end
    idle(1);
    bus.iHSEL = 1'b1;
    bus.iHTRANS = HTRANS_NONSEQ;
    bus.iHADDR = 32'h10;
    bus.iHWRITE = 1'b0;
    bus.iHSIZE = HSIZE_WORD;
    bus.iPREADY = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge iHCLK);
      bus.iHSEL = 1'b0;
      bus.iHTRANS = HTRANS_IDLE;
      if (bus.oPENABLE) break;
    end
    check("rst_reached_access", 64'(bus.oPENABLE), 64'd1);
    #2 iHRESETn = 1'b0;
    #1;
    check("async_rst_psel", 64'(bus.oPSEL), 64'd0);
    check("async_rst_penable", 64'(bus.oPENABLE), 64'd0);
    check("async_rst_hreadyout", 64'(bus.oHREADYOUT), 64'd1);
    check("async_rst_hresp", 64'(bus.oHRESP), 64'd0);
    check("async_rst_paddr", 64'(bus.oPADDR), 64'd0);
    check("async_rst_hrdata", 64'(bus.oHRDATA), 64'd0);
    @(negedge iHCLK);
    iHRESETn = 1'b1;
    lastRd = '0;
    @(negedge iHCLK);
    check("post_rst_idle", 64'(bus.oHREADYOUT), 64'd1);
    xfer(0, 32'h14, 32'h0, HSIZE_WORD, 1, 0, 32'h0BAD_F00D);
    for (int n = 0; n < 40; n++) begin
      logic [2:0] sz;
      int w;
      sz = $urandom_range(7) == 0 ? 3'($urandom_range(7)) : HSIZE_WORD;
      w = $urandom_range(9) == 0 ? $urandom_range(TO + 1, TO - 2) : $urandom_range(4);
      xfer(1'($urandom_range(1)), $urandom, $urandom, sz, w, $urandom_range(5) == 0, $urandom);
      idle($urandom_range(2));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ahb2apb_bridge.md
# ahb2apb_bridge

Single-clock AHB-Lite slave to APB master bridge that sits directly upstream of the GPIO APB slave in the LED subsystem. It converts each AHB word transfer into one APB SETUP/ACCESS sequence and holds the AHB data phase with wait states until APB completes. It returns APB read data and error status on the AHB response channel. PCLK is the same clock as HCLK; no clock-domain crossing.

## Interface

- ADDR_WIDTH, 32, width of iHADDR/oPADDR
- TIMEOUT, 16, max ACCESS cycles with iPREADY low before abort with ERROR; 0 disables
- iHCLK  in  1  bus clock (shared AHB/APB)
- iHRESETn  in  1  reset; asynchronous assert, active-low
- iHSEL  in  1  slave select from AHB decoder
- iHADDR  in  ADDR_WIDTH  address phase address
- iHWRITE  in  1  1 = write
- iHTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- iHSIZE  in  3  transfer size; only 3'b010 (word) supported
- iHWDATA  in  32  write data, valid in data phase
- iHREADY  in  1  bus-level ready (previous transfer complete)
- oHREADYOUT  out  1  data-phase complete
- oHRESP  out  1  0 = OKAY, 1 = ERROR
- oHRDATA  out  32  read data
- oPSEL, oPENABLE, oPWRITE  out  1 each  APB control
- oPADDR  out  ADDR_WIDTH  APB address, bits [1:0] forced 0
- oPWDATA  out  32  APB write data
- iPRDATA  in  32  APB read data
- iPREADY  in  1  APB ready; tie 1 for slaves without PREADY
- iPSLVERR  in  1  APB error; tie 0 if unused

## Operation

- Accept = iHSEL & iHREADY & iHTRANS[1]; sampled only in IDLE, DONE, ERR2. On accept latch address, write, size.
- States: IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2.
- IDLE: oHREADYOUT=1, oHRESP=0. Accept + iHSIZE≠010 → ERR1 (no APB access). Accept + write → WDATA. Accept + read → SETUP.
- WDATA: oHREADYOUT=0; capture iHWDATA into oPWDATA; → SETUP.
- SETUP: oPSEL=1, oPENABLE=0; oPADDR/oPWRITE/oPWDATA stable; → ACCESS.
- ACCESS: oPSEL=1, oPENABLE=1. iPREADY=1: reads capture iPRDATA into oHRDATA; iPSLVERR=1 → ERR1, else → DONE. iPREADY=0: stay, increment wait counter; counter reaching TIMEOUT → ERR1 with oPSEL/oPENABLE dropped.
- DONE: oHREADYOUT=1, oHRESP=0; new accept handled as in IDLE, else → IDLE.
- ERR1: oHREADYOUT=0, oHRESP=1 → ERR2. ERR2: oHREADYOUT=1, oHRESP=1; accept handled as in IDLE, else → IDLE.
- BUSY/IDLE HTRANS or iHSEL=0: no state change, OKAY zero-wait response.
- oPSEL, oPENABLE, oPADDR, oPWRITE, oPWDATA do not change between SETUP and end of ACCESS.
- oHRDATA holds last read value until next read completes.

## Timing

- Reset (async, any state, mid-transfer included): state IDLE; oHREADYOUT=1; oHRESP=0; oPSEL=0; oPENABLE=0; oPWRITE=0; oPADDR=0; oPWDATA=0; oHRDATA=0; wait counter=0. Interrupted APB transfer is abandoned, not completed.
- Read, iPREADY=1: address T0, SETUP T1, ACCESS T2, DONE T3 (oHREADYOUT=1, data valid); 2 wait states.
- Write, iPREADY=1: address T0, WDATA T1, SETUP T2, ACCESS T3, DONE T4; 3 wait states.
- Each cycle of iPREADY=0 in ACCESS adds one wait state.
- Back-to-back: an accept in DONE starts the next transfer with no IDLE cycle between.
- Error: oHRESP=1 for exactly two cycles, oHREADYOUT 0 then 1.
- Timeout: ERR1 entered in the cycle after the TIMEOUT-th low-iPREADY ACCESS cycle.

## Structure

- Shared package (amba_pkg): HTRANS codes, HRESP codes, HSIZE_WORD constant, bridge state enum.
- Single module. The wait counter is $clog2(TIMEOUT+1) bits and inline. No sub-module is warranted.

## Test plan

- Write 0x0000_00F0 to 0x4, iPREADY=1 → oPSEL high T2–T3, oPENABLE T3 only, oPADDR=0x4, oPWDATA=0xF0, oHREADYOUT=1 at T4, oHRESP=0.
- Read 0x0, iPRDATA=0xA5A5_0003 → oHRDATA=0xA5A5_0003 with oHREADYOUT=1 at T3.
- Read with iPREADY low 3 cycles → ACCESS lasts 4 cycles, APB signals stable, completes OKAY; TIMEOUT=2 variant → ERR1/ERR2 sequence, oPSEL drops.
- iPSLVERR=1 on write, and iHSIZE=000 access → two-cycle ERROR response; no oPSEL pulse for the size case.
- Back-to-back write 0x8 then read 0xC issued in DONE → second SETUP directly follows DONE; iHTRANS=BUSY → no APB activity.
- Assert iHRESETn low during ACCESS → oPSEL/oPENABLE low immediately, oHREADYOUT=1, state IDLE after release.
